// File: rtl/fsm_multi_pkg.sv
// Shared types and parameter checks for the multi-channel A-sequence controller.
package fsm_multi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_START = 2'b01,
      ST_STOP  = 2'b10,
      ST_CLEAR = 2'b11
   } state_t;

   localparam int DEB_MIN = 1;
   localparam int DEB_MAX = 15;

   function automatic logic deb_legal(input int deb);
      return (deb >= DEB_MIN) && (deb <= DEB_MAX);
   endfunction

endpackage

// File: rtl/fsm_multi_chan.sv
// One channel: input debounce, four-phase sequencer, dwell timeout,
// saturating completion counter and sticky timeout flag.
module fsm_multi_chan
   import fsm_multi_pkg::*;
#(
   parameter int DEB   = 3,
   parameter int TO_W  = 8,
   parameter int CNT_W = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             En,
   input  logic             Clr,
   input  logic [TO_W-1:0]  Timeout,
   input  logic             A,
   output logic             K1,
   output logic             K2,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] done_cnt,
   output logic             to_flag
);

   localparam logic [3:0]       DC_LAST  = 4'(DEB - 1);
   localparam logic [CNT_W-1:0] DONE_MAX = {CNT_W{1'b1}};
   localparam logic [TO_W-1:0]  TO_ZERO  = {TO_W{1'b0}};
   localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1'b1);

   logic             af_r;
   logic [3:0]       dc_r;
   state_t           st_r;
   logic [TO_W-1:0]  dwell_r;
   logic [CNT_W-1:0] done_r;
   logic             flag_r;
   logic             k1_r;
   logic             k2_r;

   state_t           next_st_s;
   logic             adv_s;
   logic             expire_s;
   logic             complete_s;

   // Next-phase decision from the filtered input; unknown codes fall back to Idle.
   always_comb begin
      adv_s     = 1'b0;
      next_st_s = st_r;
      case (st_r)
         ST_IDLE: begin
            adv_s     = af_r;
            next_st_s = af_r ? ST_START : ST_IDLE;
         end
         ST_START: begin
            adv_s     = !af_r;
            next_st_s = af_r ? ST_START : ST_STOP;
         end
         ST_STOP: begin
            adv_s     = af_r;
            next_st_s = af_r ? ST_CLEAR : ST_STOP;
         end
         ST_CLEAR: begin
            adv_s     = !af_r;
            next_st_s = af_r ? ST_CLEAR : ST_IDLE;
         end
         default: begin
            adv_s     = 1'b1;
            next_st_s = ST_IDLE;
         end
      endcase
      // A pending transition always beats the dwell limit.
      expire_s   = (Timeout != TO_ZERO) && (st_r != ST_IDLE) && !adv_s &&
                   (dwell_r == (Timeout - TO_ONE));
      complete_s = adv_s && (st_r == ST_CLEAR);
   end

   // Channel state, debounce, dwell, counters and registered outputs.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         af_r    <= 1'b0;
         dc_r    <= 4'd0;
         st_r    <= ST_IDLE;
         dwell_r <= TO_ZERO;
         done_r  <= {CNT_W{1'b0}};
         flag_r  <= 1'b0;
         k1_r    <= 1'b0;
         k2_r    <= 1'b0;
      end else begin
         if (En) begin
            if (A == af_r) begin
               dc_r <= 4'd0;
            end else if (dc_r == DC_LAST) begin
               af_r <= A;
               dc_r <= 4'd0;
            end else begin
               dc_r <= dc_r + 4'd1;
            end

            k2_r <= adv_s && (st_r == ST_STOP);
            k1_r <= (st_r == ST_CLEAR) && af_r && !expire_s;

            if (adv_s) begin
               st_r    <= next_st_s;
               dwell_r <= TO_ZERO;
            end else if (expire_s) begin
               st_r    <= ST_IDLE;
               dwell_r <= TO_ZERO;
            end else if (st_r == ST_IDLE) begin
               dwell_r <= TO_ZERO;
            end else begin
               dwell_r <= dwell_r + TO_ONE;
            end
         end else begin
            k1_r <= 1'b0;
            k2_r <= 1'b0;
         end

         if (Clr) begin
            done_r <= {CNT_W{1'b0}};
            flag_r <= 1'b0;
         end else begin
            if (En && expire_s) begin
               flag_r <= 1'b1;
            end
            if (En && complete_s && (done_r != DONE_MAX)) begin
               done_r <= done_r + CNT_W'(1'b1);
            end
         end
      end
   end

   assign K1       = k1_r;
   assign K2       = k2_r;
   assign state    = st_r;
   assign done_cnt = done_r;
   assign to_flag  = flag_r;

endmodule

// File: rtl/fsm_multi.sv
// CH independent A-sequence channels packed onto flat output buses.
module fsm_multi
   import fsm_multi_pkg::*;
#(
   parameter int CH    = 4,
   parameter int DEB   = 3,
   parameter int TO_W  = 8,
   parameter int CNT_W = 8
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                En,
   input  logic                Clr,
   input  logic [TO_W-1:0]     Timeout,
   input  logic [CH-1:0]       A,
   output logic [CH-1:0]       K1,
   output logic [CH-1:0]       K2,
   output logic [2*CH-1:0]     state,
   output logic [CH*CNT_W-1:0] done_cnt,
   output logic [CH-1:0]       to_flag
);

   if (!deb_legal(DEB)) begin : g_deb_range
      $error("fsm_multi: DEB must lie in 1..15");
   end

   for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      fsm_multi_chan #(
         .DEB   (DEB),
         .TO_W  (TO_W),
         .CNT_W (CNT_W)
      ) u_chan (
         .Clock    (Clock),
         .Reset    (Reset),
         .En       (En),
         .Clr      (Clr),
         .Timeout  (Timeout),
         .A        (A[gi]),
         .K1       (K1[gi]),
         .K2       (K2[gi]),
         .state    (state[2*gi +: 2]),
         .done_cnt (done_cnt[gi*CNT_W +: CNT_W]),
         .to_flag  (to_flag[gi])
      );
   end

endmodule

// File: doc/fsm_multi.md
# fsm_multi

Multi-channel, parametrised generation of the team's four-phase A-sequence controller (Idle → Start → Stop → Clear). Each of CH independent channels debounces its input, runs the four-phase sequence, and drives a K2 pulse and K1 hold output. Each channel also counts completed sequences and aborts stalled sequences on a programmable timeout. It sits between raw control inputs and downstream actuator logic.

## Interface
- CH, 4: number of independent channels.
- DEB, 3: debounce length in cycles. Legal range is 1..15.
- TO_W, 8: width of the timeout value and of the per-channel dwell counter.
- CNT_W, 8: width of the per-channel completed-sequence counter.
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- En  in  1  global enable. When 0, all channel state is frozen.
- Clr  in  1  clears done_cnt and to_flag for all channels.
- Timeout  in  TO_W  dwell limit in cycles. 0 disables the timeout.
- A  in  CH  raw per-channel sequence input.
- K1  out  CH  hold output, registered.
- K2  out  CH  one-cycle pulse output, registered.
- state  out  2*CH  per-channel state; channel i occupies bits [2i+1:2i].
- done_cnt  out  CH*CNT_W  per-channel saturating count of completed sequences.
- to_flag  out  CH  per-channel sticky timeout flag.

## Operation
- State encoding: Idle=00, Start=01, Stop=10, Clear=11.
- Debounce, per channel. Registers are the filtered value af and a counter dc.
  - A == af: dc ← 0.
  - A ≠ af and dc == DEB-1: af ← A, dc ← 0.
  - A ≠ af otherwise: dc ← dc+1.
- FSM, per channel, evaluated on af:
  - Idle → Start when af=1.
  - Start → Stop when af=0.
  - Stop → Clear when af=1. K2 ← 1 on this transition edge.
  - Clear → Idle when af=0. done_cnt increments on this edge and saturates at all-ones.
  - All other conditions: the channel holds its state.
- Outputs:
  - K2 ← 1 only on the Stop→Clear edge; otherwise 0.
  - K1 ← 1 on edges where the channel is in Clear and af=1, i.e. stays in Clear; otherwise 0.
- Timeout, per channel:
  - The dwell counter clears on every state change and is held at 0 while in Idle. Otherwise it increments each enabled cycle.
  - When Timeout ≠ 0 and dwell == Timeout-1 on an edge with no transition pending, the channel goes to Idle, to_flag ← 1, and K1, K2 ← 0. done_cnt does not change.
  - If a legal transition and the timeout fall on the same edge, the transition wins and dwell clears.
- En=0: state, af, dc, dwell and done_cnt hold; K1 and K2 ← 0. Clr is still honoured.
- Clr: done_cnt ← 0 and to_flag ← 0. Clr beats a simultaneous increment or timeout set.
- An illegal state code (unreachable) recovers to Idle on the next edge.

## Timing
- Reset=0 at an edge gives, at that edge: state=Idle, K1=0, K2=0, af=0, dc=0, dwell=0, done_cnt=0, to_flag=0 on all channels.
- Reset takes effect the same way mid-sequence.
- Debounce latency: the first edge sampling a changed A is edge n. af updates at edge n+DEB-1. The state changes at edge n+DEB.
- K2 is high for exactly the one cycle following the Stop→Clear edge.
- K1 first rises one edge after Clear is entered, provided af is still 1.
- Channels are fully independent; simultaneous events on different channels do not interact.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package fsm_multi_pkg holds:
  - the state typedef and its four encodings;
  - the DEB legal range check.
- Sub-module fsm_multi_chan holds one channel's debounce, FSM, dwell counter, done counter and flag.
- The top instantiates fsm_multi_chan CH times with a generate loop and packs the outputs into the flat buses.

## Test plan
- Reset: hold Reset=0 with arbitrary A for 3 cycles → every state=00, K1=K2=0, done_cnt=0, to_flag=0.
- Full sequence: DEB=3, ch0 A=1,0,1,0, each level held 5 cycles.
  - State reaches 01, 10, 11 and returns to 00, each change occurring 3 edges after the corresponding A change.
  - K2 is high for 1 cycle.
  - K1 is high from the second cycle in Clear until the state leaves Clear.
  - done_cnt[0] = 1.
- Glitch rejection: 2-cycle A pulses on ch1 with DEB=3 → state stays 00 and af never changes.
- Timeout: Timeout=10, ch2 driven to Start and held → returns to Idle exactly 10 cycles after entering Start, to_flag[2]=1, done_cnt[2] unchanged.
  - Clr asserted for one cycle on the same edge as a completion → done_cnt=0.
- Saturation and enable: CNT_W=2, five full sequences → done_cnt=3.
  - En=0 mid-sequence for 20 cycles → state frozen and K1=K2=0.
  - Resumes correctly once En returns to 1.
- Independence: all CH channels run staggered sequences concurrently → per-channel results match a per-channel reference model.
